// File: rtl/bpnn_delta_trainer_if.sv
// bpnn_delta_trainer_if: sample handshake, prediction result and weight readback bus of the perceptron trainer
//   master (sample source): drives in_valid, train, x, desired, w_addr
//   slave (trainer): drives in_ready, y, out_valid, err_count, w_rdata
interface bpnn_delta_trainer_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 9,
    parameter int WW    = 16
);
    localparam int NW   = N_OUT * (N_IN + 1);
    localparam int AWID = $clog2(NW);
    logic                         in_valid;
    logic                         in_ready;
    logic                         train;
    logic [N_IN*DW-1:0]           x;
    logic [N_OUT-1:0]             desired;
    logic [N_OUT-1:0]             y;
    logic                         out_valid;
    logic [$clog2(N_OUT+1)-1:0]   err_count;
    logic [AWID-1:0]              w_addr;
    logic [WW-1:0]                w_rdata;
    modport master (
        output in_valid, train, x, desired, w_addr,
        input  in_ready, y, out_valid, err_count, w_rdata
    );
    modport slave (
        input  in_valid, train, x, desired, w_addr,
        output in_ready, y, out_valid, err_count, w_rdata
    );
endinterface

// File: rtl/bpnn_delta_trainer.sv
// bpnn_delta_trainer: single-layer perceptron, one time-shared MAC, online delta-rule training
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation, reloads weights)
//   bus  : bpnn_delta_trainer_if.slave (sample handshake, y/err_count result, weight readback)
//   BPNN_WSAT_EN: when defined, weight/bias updates saturate; otherwise they wrap modulo 2^WW
module bpnn_delta_trainer #(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 2,
    parameter int DW       = 9,
    parameter int WW       = 16,
    parameter int LR_SHIFT = 2,
    parameter int W_INIT   = 0
) (
    input logic clk,
    input logic rst,
    bpnn_delta_trainer_if.slave bus
);
    localparam int NW   = N_OUT * (N_IN + 1);
    localparam int AWID = $clog2(NW);
    localparam int IW   = $clog2(N_IN + 1);
    localparam int JW   = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam int CW   = $clog2(N_OUT + 1);
    localparam int AW   = WW + DW + $clog2(N_IN + 2);
    localparam logic signed [DW-1:0] B = DW'(2 ** (DW - 2));

    typedef enum logic [1:0] {IDLE, MAC, UPD, DONE} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          i;
    logic [JW-1:0]          j;
    logic [AWID-1:0]        idx;
    logic [N_IN*DW-1:0]     xr;
    logic [N_OUT-1:0]       dr, yp, yp_nxt, yr;
    logic                   tr;
    logic [CW-1:0]          err_r;
    logic signed [AW-1:0]   acc, acc_nxt;
    logic signed [WW+DW-1:0] prod;
    logic signed [DW-1:0]   opnd;
    logic signed [DW:0]     opx, ex;
    logic signed [WW:0]     wsum;
    logic signed [WW-1:0]   wnew;
    logic signed [WW-1:0]   w [NW];
    logic                   bias_cyc, last, e_pos, e_neg;

    function automatic logic [CW-1:0] popcnt(input logic [N_OUT-1:0] v);
        return CW'($countones(v));
    endfunction

    // Slot N_IN of every neuron is its bias; it multiplies the constant B instead of an input.
    assign bias_cyc = i == IW'(N_IN);
    assign last     = bias_cyc && j == JW'(N_OUT - 1);
    assign idx      = AWID'(j) * AWID'(N_IN + 1) + AWID'(i);
    assign opnd     = bias_cyc ? B : $signed(xr[i*DW +: DW]);
    assign prod     = w[idx] * opnd;
    assign acc_nxt  = acc + AW'(prod);

    always_comb begin
        yp_nxt    = yp;
        yp_nxt[j] = ~acc_nxt[AW-1];
    end

    // e_j = desired_j - y_j reduces to a sign select on the operand; one extra bit holds -(-2^(DW-1)).
    assign e_pos = dr[j] & ~yp[j];
    assign e_neg = ~dr[j] & yp[j];
    assign opx   = opnd;
    assign ex    = e_pos ? opx : (e_neg ? -opx : '0);
    assign wsum  = (WW+1)'(w[idx]) + (WW+1)'(ex >>> LR_SHIFT);

`ifdef BPNN_WSAT_EN
    assign wnew = (wsum[WW] != wsum[WW-1]) ? (wsum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}})
                                           : wsum[WW-1:0];
`else
    assign wnew = wsum[WW-1:0];
`endif

    assign bus.y         = yr;
    assign bus.err_count = err_r;
    assign bus.w_rdata   = ({1'b0, bus.w_addr} < (AWID+1)'(NW)) ? w[bus.w_addr] : '0;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                state_nxt    = bus.in_valid ? MAC : IDLE;
            end
            MAC:  state_nxt = last ? (tr ? UPD : DONE) : MAC;
            UPD:  state_nxt = last ? DONE : UPD;
            DONE: begin
                bus.out_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i     <= '0;
            j     <= '0;
            acc   <= '0;
            xr    <= '0;
            dr    <= '0;
            tr    <= 1'b0;
            yp    <= '0;
            yr    <= '0;
            err_r <= '0;
            for (int k = 0; k < NW; k++) w[k] <= (k % (N_IN + 1) == N_IN) ? '0 : WW'(W_INIT);
        end else begin
            if (state == IDLE && bus.in_valid) begin
                xr  <= bus.x;
                dr  <= bus.desired;
                tr  <= bus.train;
                i   <= '0;
                j   <= '0;
                acc <= '0;
            end
            if (state == MAC || state == UPD) begin
                i <= bias_cyc ? '0 : i + 1'b1;
                j <= last ? '0 : (bias_cyc ? j + 1'b1 : j);
            end
            if (state == MAC) begin
                acc <= bias_cyc ? '0 : acc_nxt;
                if (bias_cyc) yp <= yp_nxt;
                if (last && !tr) begin
                    yr    <= yp_nxt;
                    err_r <= popcnt(yp_nxt ^ dr);
                end
            end
            if (state == UPD) begin
                w[idx] <= wnew;
                if (last) begin
                    yr    <= yp;
                    err_r <= popcnt(yp ^ dr);
                end
            end
        end
    end
endmodule

// File: tb/tb_bpnn_delta_trainer.sv
// tb_bpnn_delta_trainer: randomized bench for bpnn_delta_trainer against an arithmetic perceptron model
module tb_bpnn_delta_trainer;
    localparam int N_IN     = 4;
    localparam int N_OUT    = 2;
    localparam int DW       = 9;
    localparam int WW       = 16;
    localparam int LR_SHIFT = 2;
    localparam int NW       = N_OUT * (N_IN + 1);
    localparam int AWID     = $clog2(NW);
    localparam int B        = 2 ** (DW - 2);

    logic clk, rst, sel;
    logic in_valid, train;
    logic [N_IN*DW-1:0] x;
    logic [N_OUT-1:0] desired, y;
    logic [AWID-1:0] w_addr;
    logic in_ready, out_valid;
    logic [$clog2(N_OUT+1)-1:0] err_count;
    logic signed [WW-1:0] w_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int mw [N_OUT][N_IN+1];

    bpnn_delta_trainer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW)) if0 ();
    bpnn_delta_trainer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW)) if1 ();

    bpnn_delta_trainer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .LR_SHIFT(LR_SHIFT), .W_INIT(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bpnn_delta_trainer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .LR_SHIFT(LR_SHIFT), .W_INIT(32767))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.in_valid = in_valid;
    assign if0.train    = train;
    assign if0.x        = x;
    assign if0.desired  = desired;
    assign if0.w_addr   = w_addr;
    assign if1.in_valid = in_valid;
    assign if1.train    = train;
    assign if1.x        = x;
    assign if1.desired  = desired;
    assign if1.w_addr   = w_addr;
    assign in_ready  = sel ? if1.in_ready  : if0.in_ready;
    assign out_valid = sel ? if1.out_valid : if0.out_valid;
    assign y         = sel ? if1.y         : if0.y;
    assign err_count = sel ? if1.err_count : if0.err_count;
    assign w_rd      = sel ? if1.w_rdata   : if0.w_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fix(input longint v);
`ifdef BPNN_WSAT_EN
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : int'(v));
`else
        longint m;
        m = v & 65535;
        return int'(m >= 32768 ? m - 65536 : m);
`endif
    endfunction

    task automatic init_model(input int wi);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i <= N_IN; i++) mw[j][i] = (i == N_IN) ? 0 : wi;
    endtask

    task automatic chk_weights(input string tag);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i <= N_IN; i++) begin
                w_addr = AWID'(j * (N_IN + 1) + i);
                #1;
                chk($sformatf("%s w[%0d][%0d]", tag, j, i), w_rd, mw[j][i]);
            end
    endtask

    // Present one sample at a negedge in IDLE, track it to out_valid and compare with the model.
    task automatic send(input string tag, input bit tr, input int xs[N_IN], input bit [N_OUT-1:0] d);
        bit [N_OUT-1:0] ye;
        int ee, n;
        ye = '0;
        for (int j = 0; j < N_OUT; j++) begin
            longint s = 0;
            for (int i = 0; i < N_IN; i++) s += longint'(mw[j][i]) * xs[i];
            s += longint'(mw[j][N_IN]) * B;
            ye[j] = s >= 0;
        end
        ee = $countones(ye ^ d);
        if (tr)
            for (int j = 0; j < N_OUT; j++) begin
                int e = int'(d[j]) - int'(ye[j]);
                for (int i = 0; i <= N_IN; i++) begin
                    int v = (i == N_IN) ? B : xs[i];
                    mw[j][i] = fix(longint'(mw[j][i]) + ((e * v) >>> LR_SHIFT));
                end
            end
        chk({tag, " ready"}, in_ready, 1);
        in_valid = 1'b1;
        train    = tr;
        desired  = d;
        for (int i = 0; i < N_IN; i++) x[i*DW +: DW] = DW'(xs[i]);
        @(negedge clk);
        n = 1;
        chk({tag, " busy"}, in_ready, 0);
        while (!out_valid && n < 100) begin
            x       = {$urandom, $urandom};
            desired = N_OUT'($urandom);
            train   = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, n, tr ? 2 * NW + 1 : NW + 1);
        chk({tag, " y"}, y, ye);
        chk({tag, " err_count"}, err_count, ee);
        @(negedge clk);
        chk({tag, " pulse"}, out_valid, 0);
        chk({tag, " ready again"}, in_ready, 1);
    endtask

    task automatic do_reset(input int wi);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        init_model(wi);
    endtask

    task automatic rand_x(output int xs[N_IN]);
        for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 511)) - 256;
    endtask

    initial begin
        int xs[N_IN];
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; train = 1'b0; x = '0; desired = '0; w_addr = '0;
        @(negedge clk);
        do_reset(0);
        chk("reset in_ready", in_ready, 1);
        chk("reset y", y, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset err_count", err_count, 0);
        chk_weights("reset");

        xs = '{196, 243, 106, 149};
        send("infer0", 1'b0, xs, 2'b10);
        send("train0", 1'b1, xs, 2'b10);
        chk("train0 w00", w_rd, w_rd);
        chk_weights("train0");
        w_addr = 0;
        #1 chk("train0 w00 const", w_rd, -49);
        send("replay", 1'b0, xs, 2'b10);

        for (int k = 0; k < 30; k++) begin
            rand_x(xs);
            send($sformatf("rnd%0d", k), 1'($urandom), xs, N_OUT'($urandom));
        end
        chk_weights("rnd");

        rand_x(xs);
        in_valid = 1'b1; train = 1'b1; desired = 2'b01;
        for (int i = 0; i < N_IN; i++) x[i*DW +: DW] = DW'(xs[i]);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("abort no out_valid", out_valid, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        init_model(0);
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        chk("abort y", y, 0);
        chk_weights("abort");
        rand_x(xs);
        send("after abort", 1'b1, xs, 2'b11);
        chk_weights("after abort");

        sel = 1'b1;
        do_reset(32767);
        chk_weights("winit");
        xs = '{255, -256, 0, 0};
        send("wrap", 1'b1, xs, 2'b11);
        chk_weights("wrap");
        for (int k = 0; k < 12; k++) begin
            rand_x(xs);
            send($sformatf("hi%0d", k), 1'($urandom), xs, N_OUT'($urandom));
        end
        chk_weights("hi");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
